// File: rtl/audio_out_pkg.sv
// Shared types and helpers for the TDM audio output serializer.
package audio_out_pkg;

  // Serializer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_SHIFT = 2'd2,
    ST_PAD   = 2'd3
  } out_state_e;

  // Number of serial bits carried by one frame
  function automatic int frame_bits(input int num_channels, input int data_width);
    return num_channels * data_width;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; rd_data always presents the head entry.
module sync_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr, rptr;
  logic                  do_wr, do_rd;

  // Extra pointer bit distinguishes full from empty
  assign count   = wptr - rptr;
  assign full    = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign empty   = (wptr == rptr);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rptr[ADDR_WIDTH-1:0]];

  // Pointer update; full is judged before any same-cycle read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[ADDR_WIDTH-1:0]] <= wr_data;
  end

endmodule

// File: rtl/audio_out_tdm_serializer.sv
// TDM audio serializer: buffers whole frames and shifts them out MSB first
// on bit-clock falling-edge strobes, aligned to frame-sync strobes.
module audio_out_tdm_serializer
  import audio_out_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_CHANNELS = 2,
  parameter int FIFO_DEPTH   = 128,
  parameter int ADDR_WIDTH   = 7
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               bit_clk_rising_edge,
  input  logic                               bit_clk_falling_edge,
  input  logic                               frame_sync_rising_edge,
  input  logic                               i2s_mode,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] frame_data,
  input  logic                               frame_data_en,
  input  logic                               clear_flags,
  output logic [ADDR_WIDTH:0]                fifo_write_space,
  output logic                               underrun,
  output logic                               overflow,
  output logic                               frame_active,
  output logic                               serial_audio_out_data
);

  localparam int FRAME_W = frame_bits(NUM_CHANNELS, DATA_WIDTH);
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  out_state_e          state;
  logic [FRAME_W-1:0]  shreg, fifo_rd_data;
  logic [CNT_W-1:0]    bit_cnt;
  logic                fifo_full, fifo_empty, pop;
  logic [ADDR_WIDTH:0] fifo_count;
  logic                underrun_set, overflow_set;

  // Rising bit-clock strobe only matters for external alignment checks
  logic unused_bclk_rise;
  assign unused_bclk_rise = bit_clk_rising_edge;

  assign pop          = frame_sync_rising_edge && !fifo_empty;
  assign underrun_set = frame_sync_rising_edge && fifo_empty;
  assign overflow_set = frame_data_en && fifo_full;
  assign frame_active = (state == ST_DELAY) || (state == ST_SHIFT);

  sync_fifo #(
    .DATA_WIDTH (FRAME_W),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (frame_data_en),
    .wr_data (frame_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Frame FSM and shifter; frame sync overrides any bit-clock strobe.
  // The latched i2s_mode is held implicitly by the DELAY/SHIFT choice.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (frame_sync_rising_edge) begin
      bit_cnt <= '0;
      if (!fifo_empty) begin
        shreg <= fifo_rd_data;
        state <= i2s_mode ? ST_DELAY : ST_SHIFT;
      end else begin
        // Underrun: emit a silent frame without consuming, keeping channel order
        shreg <= '0;
        state <= ST_PAD;
      end
    end else if (bit_clk_falling_edge) begin
      case (state)
        ST_DELAY: state <= ST_SHIFT;
        ST_SHIFT: begin
          shreg   <= {shreg[FRAME_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) state <= ST_PAD;
        end
        default: ;
      endcase
    end
  end

  // Registered serial output: shifter MSB while shifting, else silence
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) serial_audio_out_data <= 1'b0;
    else          serial_audio_out_data <= (state == ST_SHIFT) && shreg[FRAME_W-1];
  end

  // Free-space report, one clk behind the FIFO occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fifo_write_space <= '0;
    else          fifo_write_space <= (ADDR_WIDTH+1)'(FIFO_DEPTH) - fifo_count;
  end

  // Sticky flags; a same-cycle set beats clear_flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (underrun_set)     underrun <= 1'b1;
      else if (clear_flags) underrun <= 1'b0;
      if (overflow_set)     overflow <= 1'b1;
      else if (clear_flags) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_out_tdm_serializer.sv
// Bench for audio_out_tdm_serializer: two instances (2x32 and 4x16, both
// 64-bit frames) share stimulus and are checked against a frame-level model.
module tb_audio_out_tdm_serializer;

  localparam int FW    = 64;
  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bclk_rise = 1'b0, bclk_fall = 1'b0, fsync = 1'b0, i2s = 1'b0;
  logic [63:0] frame_data = '0;
  logic        fden = 1'b0, clr = 1'b0;

  logic [7:0]  space_a, space_b;
  logic        und_a, und_b, ovf_a, ovf_b, act_a, act_b, sdo_a, sdo_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  audio_out_tdm_serializer #(.DATA_WIDTH(32), .NUM_CHANNELS(2), .FIFO_DEPTH(128), .ADDR_WIDTH(7)) dut_a (
    .clk(clk), .reset_n(reset_n), .bit_clk_rising_edge(bclk_rise), .bit_clk_falling_edge(bclk_fall),
    .frame_sync_rising_edge(fsync), .i2s_mode(i2s), .frame_data(frame_data), .frame_data_en(fden),
    .clear_flags(clr), .fifo_write_space(space_a), .underrun(und_a), .overflow(ovf_a),
    .frame_active(act_a), .serial_audio_out_data(sdo_a));

  audio_out_tdm_serializer #(.DATA_WIDTH(16), .NUM_CHANNELS(4), .FIFO_DEPTH(128), .ADDR_WIDTH(7)) dut_b (
    .clk(clk), .reset_n(reset_n), .bit_clk_rising_edge(bclk_rise), .bit_clk_falling_edge(bclk_fall),
    .frame_sync_rising_edge(fsync), .i2s_mode(i2s), .frame_data(frame_data), .frame_data_en(fden),
    .clear_flags(clr), .fifo_write_space(space_b), .underrun(und_b), .overflow(ovf_b),
    .frame_active(act_b), .serial_audio_out_data(sdo_b));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: a queue of frames, the frame being played, and the
  // number of falling edges seen since its frame sync.
  logic [63:0] mq[$];
  logic [63:0] m_frame = '0;
  bit          m_valid = 1'b0, m_mode = 1'b0;
  int          m_fe = 0;
  logic        exp_sdo = 1'b0, exp_und = 1'b0, exp_ovf = 1'b0;
  logic [7:0]  exp_space = '0;
  logic        exp_active;

  assign exp_active = m_valid && (m_fe < FW + int'(m_mode));

  always @(posedge clk or negedge reset_n) begin
    int pre, k;
    if (!reset_n) begin
      mq.delete();
      m_valid = 1'b0; m_mode = 1'b0; m_fe = 0; m_frame = '0;
      exp_sdo = 1'b0; exp_space = '0; exp_und = 1'b0; exp_ovf = 1'b0;
    end else begin
      // Bit k of the frame is on the line when k edges (plus the I2S delay) have passed
      k = m_fe - int'(m_mode);
      exp_sdo = (m_valid && k >= 0 && k < FW) ? m_frame[FW-1-k] : 1'b0;
      pre = mq.size();
      exp_space = 8'(DEPTH - pre);
      if (clr) begin exp_und = 1'b0; exp_ovf = 1'b0; end
      if (fsync) begin
        if (pre > 0) begin
          m_frame = mq.pop_front(); m_mode = i2s; m_valid = 1'b1; m_fe = 0;
        end else begin
          m_valid = 1'b0; exp_und = 1'b1;
        end
      end else if (bclk_fall && m_valid && m_fe < FW + 1) begin
        m_fe++;
      end
      if (fden) begin
        if (pre < DEPTH) mq.push_back(frame_data);
        else exp_ovf = 1'b1;
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    chk("sdo_a", sdo_a, exp_sdo);       chk("sdo_b", sdo_b, exp_sdo);
    chk("active_a", act_a, exp_active); chk("active_b", act_b, exp_active);
    chk("space_a", space_a, exp_space); chk("space_b", space_b, exp_space);
    chk("underrun_a", und_a, exp_und);  chk("underrun_b", und_b, exp_und);
    chk("overflow_a", ovf_a, exp_ovf);  chk("overflow_b", ovf_b, exp_ovf);
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic write_frame(input logic [63:0] d);
    fden = 1'b1; frame_data = d; step(); fden = 1'b0;
  endtask

  task automatic sync(input bit mode);
    fsync = 1'b1; i2s = mode; step(); fsync = 1'b0;
  endtask

  // Issue n falling-edge strobes, collecting the bit on the line after each
  task automatic run_bits(input int n, output logic [127:0] ga, output logic [127:0] gb);
    ga = '0; gb = '0;
    for (int i = 0; i < n; i++) begin
      bclk_fall = 1'b1; step();
      ga = {ga[126:0], sdo_a}; gb = {gb[126:0], sdo_b};
      bclk_fall = 1'b0; bclk_rise = 1'b1; step(); bclk_rise = 1'b0;
    end
  endtask

  localparam logic [63:0] PAT = 64'hA5A5A5A5_0000FFFF;
  localparam logic [63:0] D2  = 64'h12345678_9ABCDEF0;

  initial begin
    logic [127:0] ga, gb;
    logic [63:0]  t1, t2;

    // Reset state
    repeat (3) step();
    chk("reset_space", space_a, 0);
    chk("reset_sdo", sdo_a, 0);
    reset_n = 1'b1; step();
    chk("post_reset_space", space_a, 128);

    // Three frames, then left-justified playout
    repeat (3) write_frame(PAT);
    step(); step();
    chk("space_after_3", space_a, 125);
    sync(1'b0); run_bits(66, ga, gb);
    chk("lj_stream_a", ga[65:0], {PAT, 2'b00});
    chk("lj_stream_b", gb[65:0], {PAT, 2'b00});
    chk("lj_pad_inactive", act_a, 0);

    // I2S: one-bit delay
    sync(1'b1); run_bits(66, ga, gb);
    chk("i2s_stream_a", ga[65:0], {1'b0, PAT, 1'b0});
    sync(1'b0); run_bits(64, ga, gb);
    chk("third_frame", ga[63:0], PAT);

    // Underrun on empty FIFO, then a fresh frame starts at ch0
    sync(1'b0);
    chk("underrun_set", und_a, 1);
    run_bits(64, ga, gb);
    chk("underrun_zeros", ga[63:0], 64'h0);
    chk("underrun_no_pop", space_a, 128);
    write_frame(D2);
    sync(1'b0); run_bits(64, ga, gb);
    chk("after_underrun", ga[63:0], D2);
    clr = 1'b1; step(); clr = 1'b0;
    chk("underrun_clear", und_a, 0);

    // Short frame: truncate after 40 bits, next frame starts at its MSB
    t1 = {$urandom, $urandom}; t2 = {$urandom, $urandom};
    write_frame(t1); write_frame(t2);
    sync(1'b0); run_bits(40, ga, gb);
    chk("trunc_first_b", gb[39:0], t1[63:24]);
    sync(1'b0); run_bits(66, ga, gb);
    chk("trunc_next_a", ga[65:0], {t2, 2'b00});
    chk("trunc_next_b", gb[65:0], {t2, 2'b00});

    // Overflow: 129 writes, last one lost
    for (int i = 0; i < 129; i++) write_frame(64'(i + 1));
    step(); step();
    chk("full_space", space_a, 0);
    chk("overflow_set", ovf_a, 1);
    for (int i = 0; i < 128; i++) sync(1'b0);
    step();
    chk("drain_no_underrun", und_a, 0);
    sync(1'b0);
    chk("frame129_lost", und_a, 1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("overflow_clear", ovf_a, 0);

    // Reset mid-shift
    write_frame(64'hFFFF_FFFF_FFFF_FFFF);
    sync(1'b0); run_bits(10, ga, gb);
    chk("pre_reset_sdo", sdo_a, 1);
    chk("pre_reset_active", act_a, 1);
    reset_n = 1'b0; #1;
    chk("rst_sdo", sdo_a, 0);
    chk("rst_active", act_b, 0);
    chk("rst_space", space_a, 0);
    step(); step();
    reset_n = 1'b1; step();
    chk("rst_release_space", space_a, 128);
    chk("rst_release_idle", act_a, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 15000; c++) begin
      bclk_fall  = ($urandom_range(2) == 0);
      bclk_rise  = !bclk_fall && ($urandom_range(1) == 0);
      fsync      = ($urandom_range(199) == 0);
      i2s        = 1'($urandom_range(1));
      fden       = ($urandom_range(149) == 0);
      frame_data = {$urandom, $urandom};
      clr        = ($urandom_range(59) == 0);
      step();
    end
    bclk_fall = 1'b0; bclk_rise = 1'b0; fsync = 1'b0; fden = 1'b0; clr = 1'b0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_out_tdm_serializer.md
AUDIO_OUT_TDM_SERIALIZER -- requirements
Module: audio_out_tdm_serializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: bits per channel slot (8..32).
REQ-002 The block SHALL have parameter NUM_CHANNELS, default 2: channels per frame (1..8).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 128: frames buffered (power of 2).
REQ-004 The block SHALL have parameter ADDR_WIDTH, default 7: log2(FIFO_DEPTH).
REQ-005 The block SHALL have port clk, input, 1 bit: sole clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port bit_clk_rising_edge, input, 1 bit: one-clk strobe for the serial bit clock rising edge, unused except for alignment checks.
REQ-008 The block SHALL have port bit_clk_falling_edge, input, 1 bit: one-clk strobe that advances the shifter.
REQ-009 The block SHALL have port frame_sync_rising_edge, input, 1 bit: one-clk strobe marking frame start.
REQ-010 The block SHALL have port i2s_mode, input, 1 bit: 1 = one-bit delay after frame start; 0 = left-justified.
REQ-011 The block SHALL have port frame_data, input, NUM_CHANNELS*DATA_WIDTH bits: channel 0 in the MSBs.
REQ-012 The block SHALL have port frame_data_en, input, 1 bit: write strobe for frame_data.
REQ-013 The block SHALL have port clear_flags, input, 1 bit: synchronous clear of the sticky flags.
REQ-014 The block SHALL have port fifo_write_space, output, ADDR_WIDTH+1 bits: registered count of free frames.
REQ-015 The block SHALL have port underrun, output, 1 bit: sticky flag.
REQ-016 The block SHALL have port overflow, output, 1 bit: sticky flag.
REQ-017 The block SHALL have port frame_active, output, 1 bit: high while a frame is shifting.
REQ-018 The block SHALL have port serial_audio_out_data, output, 1 bit: registered serial data, MSB first.

Function
REQ-019 A write SHALL be accepted when frame_data_en=1 and the FIFO is not full; a write while full SHALL be dropped and SHALL set overflow, even in a pop cycle.
REQ-020 fifo_write_space SHALL be registered as FIFO_DEPTH minus the words used, with a one-clk lag, and SHALL span 0..FIFO_DEPTH.
REQ-021 The FSM SHALL have states IDLE, DELAY, SHIFT and PAD.
REQ-022 On frame_sync_rising_edge with the FIFO non-empty, the FSM SHALL pop one whole frame into the shift register, latch i2s_mode, clear the bit counter, and go to DELAY if i2s_mode=1, else SHIFT.
REQ-023 On frame_sync_rising_edge with the FIFO empty, the FSM SHALL set underrun, load zeros, go to PAD, and pop nothing, so that channel order is never skewed.
REQ-024 In DELAY the output SHALL be 0; the first bit_clk_falling_edge SHALL move the FSM to SHIFT without shifting.
REQ-025 In SHIFT, serial_audio_out_data SHALL equal the shift-register MSB, delayed one clk.
REQ-026 In SHIFT, each bit_clk_falling_edge SHALL shift left by one with zero fill and increment the bit counter.
REQ-027 After NUM_CHANNELS*DATA_WIDTH shifts, the FSM SHALL go to PAD.
REQ-028 PAD SHALL output 0 until the next frame_sync_rising_edge, which SHALL be handled per REQ-022/023.
REQ-029 A frame_sync_rising_edge in DELAY or SHIFT (short frame) SHALL abandon the remaining bits and start a new frame per REQ-022/023.
REQ-030 frame_sync_rising_edge SHALL take priority over bit_clk_falling_edge in the same clk.
REQ-031 frame_active SHALL be 1 in DELAY and SHIFT, and 0 in IDLE and PAD.
REQ-032 The bit counter SHALL be $clog2(NUM_CHANNELS*DATA_WIDTH+1) bits wide and SHALL never wrap within a frame.
REQ-033 clear_flags SHALL clear underrun and overflow, except that a set event in the same clk SHALL win.

Reset
REQ-034 While reset_n=0: FSM=IDLE, FIFO empty, shift register=0, serial_audio_out_data=0, fifo_write_space=0, underrun=0, overflow=0, frame_active=0.
REQ-035 In the first clk after reset_n deasserts, fifo_write_space SHALL become FIFO_DEPTH.
REQ-036 A reset mid-frame SHALL drop the frame in progress and all buffered frames.

Structure
REQ-037 Package audio_out_pkg SHALL hold the FSM state enum and the frame-bit-count helper function.
REQ-038 A single sub-module sync_fifo (parameters DATA_WIDTH, DEPTH, ADDR_WIDTH; show-ahead read; async active-low reset) SHALL buffer whole frames; the FSM, the shifter and the flags SHALL live in the top level.

Verification
REQ-039 Reset, then 3 frames written (2ch x 32b, ch0=0xA5A5A5A5, ch1=0x0000FFFF), left-justified -> fifo_write_space 128->125; serial stream is the MSB-first 64 bits, then PAD zeros.
REQ-040 i2s_mode=1, same data -> one 0 bit after the frame start, then 0xA5A5A5A5, 0x0000FFFF, all one bit_clk later than in REQ-039.
REQ-041 Frame sync with the FIFO empty -> underrun=1, 64 zero bits, nothing popped; the next frame after a write outputs the correct ch0 first.
REQ-042 129 writes without reads -> fifo_write_space=0, overflow=1, the 129th frame is lost; clear_flags -> overflow=0.
REQ-043 NUM_CHANNELS=4, DATA_WIDTH=16, frame sync after 40 bits -> truncation; the new frame starts at the ch0 MSB; bit count correct.
REQ-044 reset_n pulled low mid-SHIFT -> all outputs 0 immediately; after release fifo_write_space=FIFO_DEPTH and the FSM is in IDLE.
